// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the slice-serial ALU.
//   op_t    : operation encoding presented on the op input
//   state_t : control states of the multicycle sequencer
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // Carry that seeds the least-significant slice of an operation.
  function automatic logic initial_carry(input op_t op, input logic cin);
    case (op)
      OP_ADD:  return cin;
      OP_SUB:  return 1'b1;   // two's complement: a + ~b + 1
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_slice.sv
// -----------------------------------------------------------------------------
// alu_slice
// Combinational SLICE-bit ALU slice, reused every cycle by alu_multicycle.
// Ports:
//   a, b      : operand slices
//   cin       : carry into the slice LSB
//   op        : operation (op_t)
//   s         : slice result
//   cout      : carry out of the slice MSB (0 for NOR/XOR)
//   c_msb_in  : carry into the slice MSB (0 for NOR/XOR), used for overflow
// -----------------------------------------------------------------------------
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 16
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  op_t              op,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SLICE-1:0] b_eff;
  logic [SLICE:0]   sum;
  logic             arith;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    arith    = op[1];
    b_eff    = (op == OP_SUB) ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};
    s        = sum[SLICE-1:0];
    cout     = arith & sum[SLICE];
    // The carry into a bit equals sum ^ a ^ b at that bit; this avoids a
    // second (SLICE-1)-bit adder and also works for SLICE == 1.
    c_msb_in = arith & (sum[SLICE-1] ^ a[SLICE-1] ^ b_eff[SLICE-1]);
    case (op)
      OP_NOR:  s = ~(a | b);
      OP_XOR:  s = a ^ b;
      default: s = sum[SLICE-1:0];
    endcase
  end

endmodule

// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
// Slice-serial WIDTH-bit ALU: one SLICE-bit slice per clock with a registered
// carry between slices. Valid/ready on both sides; result, carry, zero and
// signed-overflow are published together when the last slice completes.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operation handshake (ready only in IDLE)
//   a, b, cin, op       : operands, carry-in (ADD only), operation
//   out_valid/out_ready : result handshake (valid only in DONE)
//   s, cout, zero, ovf  : result and flags, held until the next completion
// -----------------------------------------------------------------------------
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int NS    = WIDTH / SLICE;
  localparam int CNT_W = (NS > 1) ? $clog2(NS) : 1;

  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("alu_multicycle: WIDTH must be a multiple of SLICE");
  end

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q, b_q;
  op_t                op_q;
  logic               carry_q;
  // Working accumulator; s_q only changes on completion, so a partially
  // computed result never reaches the output.
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   s_q;
  logic               cout_q, zero_q, ovf_q;

  logic [SLICE-1:0]   a_slice, b_slice, slice_s;
  logic               slice_cout, slice_c_msb;
  logic               last_slice;
  int                 base;

  always_comb begin
    base       = int'(cnt_q) * SLICE;
    a_slice    = a_q[base +: SLICE];
    b_slice    = b_q[base +: SLICE];
    res_d      = res_q;
    res_d[base +: SLICE] = slice_s;
    last_slice = (cnt_q == CNT_W'(NS - 1));
  end

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a        (a_slice),
    .b        (b_slice),
    .cin      (carry_q),
    .op       (op_q),
    .s        (slice_s),
    .cout     (slice_cout),
    .c_msb_in (slice_c_msb)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NOR;
      carry_q <= 1'b0;
      res_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op_t'(op);
            carry_q <= initial_carry(op_t'(op), cin);
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          res_q   <= res_d;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (last_slice) begin
            state_q <= DONE;
            s_q     <= res_d;
            cout_q  <= slice_cout;
            zero_q  <= (res_d == '0);
            // Both carries are 0 for NOR/XOR, so ovf is 0 there too.
            ovf_q   <= slice_cout ^ slice_c_msb;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
// Directed bench for alu_multicycle: default 64/16 instance plus an 8/8
// instance for the single-slice case. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;
  import alu_pkg::*;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, cin;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic        in_ready, out_valid, cout, zero, ovf;
  logic [63:0] s;

  logic        in_valid8, out_ready8, cin8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8, s8;
  logic        in_ready8, out_valid8, cout8, zero8, ovf8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(64), .SLICE(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .zero(zero), .ovf(ovf)
  );

  alu_multicycle #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .op(op8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .s(s8), .cout(cout8), .zero(zero8), .ovf(ovf8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  // Entered at a negedge with the DUT in IDLE; leaves at the negedge where
  // out_valid must first be high, checking the latency on the way.
  task automatic run_op(input string tag, input op_t o, input logic [63:0] ai,
                        input logic [63:0] bi, input logic ci);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; a = ai; b = bi; cin = ci;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_busy_in_ready"}, 64'(in_ready), 64'd0);
    repeat (NS - 1) begin
      @(negedge clk);
      check({tag, "_early_valid"}, 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic check_res(input string tag, input logic [63:0] es, input logic ec,
                           input logic ez, input logic eo);
    check({tag, "_s"},    s,           es);
    check({tag, "_cout"}, 64'(cout),   64'(ec));
    check({tag, "_zero"}, 64'(zero),   64'(ez));
    check({tag, "_ovf"},  64'(ovf),    64'(eo));
  endtask

  task automatic consume(input string tag, input logic [63:0] es);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_held_s"},     s,              es);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; op = 2'b00;
    a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; cin8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_s",         s,              64'd0);
    check("rst_flags",     {61'd0, cout, zero, ovf}, 64'd0);

    // ADD basics and carry across every slice boundary.
    run_op("add_1_1", OP_ADD, 64'd1, 64'd1, 1'b0);
    check_res("add_1_1", 64'd2, 1'b0, 1'b0, 1'b0);
    consume("add_1_1", 64'd2);

    run_op("add_ff_cin", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    check_res("add_ff_cin", 64'd0, 1'b1, 1'b1, 1'b0);
    consume("add_ff_cin", 64'd0);

    run_op("add_pos_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    check_res("add_pos_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    consume("add_pos_ovf", 64'h8000_0000_0000_0000);

    // SUB; cin must be ignored.
    run_op("sub_5_7", OP_SUB, 64'd5, 64'd7, 1'b1);
    check_res("sub_5_7", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    consume("sub_5_7", 64'hFFFF_FFFF_FFFF_FFFE);

    run_op("sub_min_1", OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b0);
    check_res("sub_min_1", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    consume("sub_min_1", 64'h7FFF_FFFF_FFFF_FFFF);

    // Logic ops; cin set to show it does not leak into the result or cout.
    run_op("nor_0_0", OP_NOR, 64'd0, 64'd0, 1'b1);
    check_res("nor_0_0", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    consume("nor_0_0", 64'hFFFF_FFFF_FFFF_FFFF);

    run_op("xor_aa_ff", OP_XOR, 64'hAAAA_AAAA_AAAA_AAAA, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check_res("xor_aa_ff", 64'h5555_5555_5555_5555, 1'b0, 1'b0, 1'b0);
    consume("xor_aa_ff", 64'h5555_5555_5555_5555);

    run_op("xor_zero", OP_XOR, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    check_res("xor_zero", 64'd0, 1'b0, 1'b1, 1'b0);
    consume("xor_zero", 64'd0);

    // Backpressure: in_valid pulses during BUSY/DONE must not be accepted.
    check("bp_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = OP_ADD; a = 64'd10; b = 64'd20; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 64'd999; b = 64'd1;               // in_valid stays high through BUSY
    repeat (NS) @(negedge clk);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_ready", 64'(in_ready),  64'd0);
      check("bp_hold_s",     s,              64'd30);
      check("bp_hold_flags", {61'd0, cout, zero, ovf}, 64'd0);
    end
    // out_ready with in_valid high in DONE: back to IDLE, no accept yet.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("sim_idle_ready", 64'(in_ready),  64'd1);
    check("sim_idle_valid", 64'(out_valid), 64'd0);
    // The still-asserted in_valid is accepted on this edge.
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("sim_accept_ready", 64'(in_ready), 64'd0);
    repeat (NS - 1) begin
      @(negedge clk);
      check("sim_early_valid", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    check("sim_out_valid", 64'(out_valid), 64'd1);
    check_res("sim", 64'd1000, 1'b0, 1'b0, 1'b0);
    consume("sim", 64'd1000);

    // Reset during the second BUSY cycle aborts the operation.
    in_valid = 1'b1; op = OP_ADD; a = 64'd5; b = 64'd6; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);                       // now in second BUSY cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready",  64'(in_ready),  64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_s",         s,              64'd0);
    repeat (NS) begin
      @(negedge clk);
      check("abort_no_valid", 64'(out_valid), 64'd0);
    end
    run_op("add_3_4", OP_ADD, 64'd3, 64'd4, 1'b0);
    check_res("add_3_4", 64'd7, 1'b0, 1'b0, 1'b0);
    consume("add_3_4", 64'd7);

    // Single-slice instance: WIDTH=8, SLICE=8.
    check("w8_in_ready", 64'(in_ready8), 64'd1);
    in_valid8 = 1'b1; op8 = OP_ADD; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    check("w8_busy_valid", 64'(out_valid8), 64'd0);
    @(negedge clk);
    check("w8_out_valid", 64'(out_valid8), 64'd1);
    check("w8_s",    64'(s8),    64'h80);
    check("w8_ovf",  64'(ovf8),  64'd1);
    check("w8_cout", 64'(cout8), 64'd0);
    check("w8_zero", 64'(zero8), 64'd0);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    check("w8_drop_valid", 64'(out_valid8), 64'd0);
    check("w8_in_ready2",  64'(in_ready8),  64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, slice-serial successor to the 64-bit combinational ALU.
- Processes a WIDTH-bit operation SLICE bits per clock, with a registered carry between slices.
- Uses valid/ready handshakes on input and output, and adds zero and signed-overflow flags.
- Sits between an operand-issue stage and a result consumer; trades latency for a short carry chain.

Parameters:
- WIDTH, 64, operand/result width in bits.
- SLICE, 16, bits processed per cycle. WIDTH % SLICE == 0 is required; elaboration-time assertion.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands/op presented
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in (ADD only)
- op  input  2  00 NOR, 01 XOR, 10 ADD, 11 SUB
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- s  output  WIDTH  result
- cout  output  1  carry-out (ADD/SUB), else 0
- zero  output  1  s == 0
- ovf  output  1  signed overflow (ADD/SUB), else 0

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- NS = WIDTH/SLICE.
- States: IDLE, BUSY, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, s=0, cout=0, zero=0, ovf=0, slice counter=0.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are registered-state decodes.
- IDLE accept (in_valid && in_ready) captures:
  - a, b, op.
  - Initial carry: cin for ADD, 1 for SUB, 0 for NOR/XOR.
  - cnt=0; next state BUSY.
- BUSY, each cycle:
  - Compute slice cnt, bits [cnt*SLICE +: SLICE], from latched a, b, carry.
  - Write that slice into the result register; carry <= slice carry-out; cnt++.
  - On cnt==NS-1, next state DONE.
- Latency: out_valid rises exactly NS cycles after the accept edge (4 cycles at defaults).
- NS==1 is legal: a single BUSY cycle.
- Arithmetic:
  - ADD: s = a+b+cin.
  - SUB: s = a+~b+1. cin is ignored; cout=1 means no borrow.
  - NOR: s = ~(a|b). XOR: s = a^b.
  - cout = carry from the MSB slice; forced 0 for NOR/XOR.
  - ovf = carry into MSB XOR carry out of MSB, for ADD/SUB only.
  - zero is computed on the full result.
  - cout/zero/ovf are registered on the BUSY->DONE transition.
- DONE:
  - s/cout/zero/ovf are held stable while out_ready=0.
  - When out_ready=1, next state is IDLE; outputs keep their last values and out_valid drops.
- Inputs in BUSY/DONE: in_valid is ignored and operands are not sampled; the upstream stage must hold them.
- Simultaneous events:
  - out_ready in DONE plus in_valid: no accept that cycle; accept occurs in IDLE the following cycle.
- Reset mid-operation: rst in any state aborts the in-flight op. Next cycle is IDLE with reset values, and no partial result becomes visible.
- s before the first completion reads 0.

Decomposition:
- Shared package alu_pkg:
  - op_t enum (OP_NOR=2'b00, OP_XOR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11).
  - state_t enum (IDLE, BUSY, DONE).
- Sub-module alu_slice: combinational SLICE-bit slice with ports a, b, cin, op, s, cout, c_msb_in. It is instantiated once and reused every cycle. c_msb_in is the carry into the slice MSB, used for ovf.

Test Plan:
(Defaults WIDTH=64, SLICE=16 unless noted.)
- ADD a=1, b=1, cin=0 -> after 4 cycles out_valid=1, s=2, cout=0, zero=0, ovf=0.
- ADD a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> s=0, cout=1, zero=1; proves carry crosses all slice boundaries.
- SUB a=5, b=7 -> s=64'hFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
- SUB a=64'h8000_0000_0000_0000, b=1 -> s=64'h7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
- NOR a=0, b=0 -> s=all ones, cout=0. XOR a=64'hAAAA…AAAA, b=all ones -> s=64'h5555…5555, cout=0, ovf=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> s and flags stable, in_ready=0. in_valid pulses during BUSY/DONE are not accepted.
- rst=1 on second BUSY cycle -> next cycle in_ready=1, out_valid=0, s=0. A following ADD 3+4 yields s=7.
- WIDTH=8, SLICE=8: ADD 8'h7F+8'h01 -> out_valid 1 cycle after accept, s=8'h80, ovf=1, cout=0.
